// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags and an iterative
// shift-add multiplier. One result register is shared by all operations.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned CW = SHW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       dif_ext;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 accept;

    // Accept only from IDLE when the output slot is empty or draining now.
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath and flags for the non-multiply operations.
    always_comb begin
        sum_ext = {1'b0, a} + {1'b0, b};
        dif_ext = {1'b0, a} - {1'b0, b};
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = sum_ext[WIDTH-1:0];
                alu_c = sum_ext[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = dif_ext[WIDTH-1:0];
                alu_c = dif_ext[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: alu_r = a ^ b;
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_SLT: alu_r = WIDTH'(($signed(a) < $signed(b)) ? 1'b1 : 1'b0);
            OP_SRL: alu_r = a >> b[SHW-1:0];
            default: alu_r = '0;
        endcase
    end

    // One multiply iteration: conditionally add the shifted multiplicand.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // Control FSM, result register and multiplier state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            r         <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state     <= S_MUL;
                            mcand     <= {{WIDTH{1'b0}}, a};
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            r         <= alu_r;
                            zero      <= (alu_r == '0);
                            carry     <= alu_c;
                            ovf       <= alu_v;
                            out_valid <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        r         <= acc_step[WIDTH-1:0];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                        carry     <= 1'b0;
                        ovf       <= |acc_step[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scenario tasks with a result scoreboard for alu_pipe (WIDTH=32).
module tb_alu_pipe;

    localparam int unsigned W = 32;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] SLT = 3'b101;
    localparam logic [2:0] SRL = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    typedef struct packed {
        logic [W-1:0] r;
        logic         zero;
        logic         carry;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         zero;
    logic         carry;
    logic         ovf;

    res_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .zero(zero), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one operation.
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t m;
        logic [W:0] s;
        logic [2*W-1:0] p;
        logic [4:0] sh;
        m = '0;
        sh = y[4:0];
        case (o)
            ADD: begin
                s = {1'b0, x} + {1'b0, y};
                m.r = s[W-1:0];
                m.carry = s[W];
                m.ovf = (x[W-1] == y[W-1]) && (m.r[W-1] != x[W-1]);
            end
            SUB: begin
                m.r = x - y;
                m.carry = (x < y);
                m.ovf = (x[W-1] != y[W-1]) && (m.r[W-1] != x[W-1]);
            end
            XOR: m.r = x ^ y;
            AND: m.r = x & y;
            OR:  m.r = x | y;
            SLT: m.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            SRL: m.r = x >> sh;
            default: begin
                p = {32'd0, x} * {32'd0, y};
                m.r = p[W-1:0];
                m.ovf = (p[2*W-1:W] != '0);
            end
        endcase
        m.zero = (m.r == '0);
        return m;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = ADD; a = '0; b = '0;
        #1;
        n_total++;
        if ({out_valid, r, zero, carry, ovf} !== '0) begin
            $display("FAIL reset_outputs: got v=%b r=%h z=%b c=%b o=%b, want all 0", out_valid, r, zero, carry, ovf);
        end else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add_ovf();
        res_t e;
        out_ready = 1'b1; in_valid = 1'b1; op = ADD; a = 32'h7FFF_FFFF; b = 32'h0000_0001;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL add_ovf_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e) $display("FAIL add_ovf: got %h/%b%b%b want %h/%b%b%b", r, zero, carry, ovf, e.r, e.zero, e.carry, e.ovf);
            else n_pass++;
        end
        n_total++;
        if ({r, zero, carry, ovf} !== {32'h8000_0000, 1'b0, 1'b0, 1'b1}) $display("FAIL add_ovf_const: got %h/%b%b%b want 80000000/001", r, zero, carry, ovf);
        else n_pass++;
    endtask

    task automatic test_sub_srl();
        res_t e;
        out_ready = 1'b1; in_valid = 1'b1; op = SUB; a = 32'd0; b = 32'd1;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL sub_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== 32'hFFFF_FFFF) $display("FAIL sub_borrow: got %h/%b%b%b want %h/%b%b%b", r, zero, carry, ovf, e.r, e.zero, e.carry, e.ovf);
            else n_pass++;
        end
        op = SRL; a = 32'h8000_0000; b = 32'h0000_003F;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL srl_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== 32'h0000_0001) $display("FAIL srl: got %h/%b%b%b want %h/%b%b%b", r, zero, carry, ovf, e.r, e.zero, e.carry, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] want_r);
        res_t e;
        int cycles;
        bit busy_ok;
        out_ready = 1'b1; in_valid = 1'b1; op = MUL; a = x; b = y;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cycles < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        n_total++;
        if (!busy_ok) $display("FAIL mul_in_ready: in_ready seen 1 while multiplying, want 0");
        else n_pass++;
        n_total++;
        if (cycles != 32) $display("FAIL mul_latency: got %0d edges want 32 (out_valid=%b)", cycles, out_valid);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL mul_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== want_r) $display("FAIL mul_result: got %h/%b%b%b want %h/%b%b%b", r, zero, carry, ovf, e.r, e.zero, e.carry, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        bit frozen_ok;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = ADD; a = 32'd1; b = 32'd2;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL bp_add_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== 32'd3) $display("FAIL bp_add: got %h want %h", r, e.r);
            else n_pass++;
        end
        op = XOR; a = 32'h0000_00F0; b = 32'h0000_00FF;
        sb.push_back(model(op, a, b));
        frozen_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || r !== 32'd3) frozen_ok = 1'b0;
            @(posedge clk); #1;
        end
        n_total++;
        if (!frozen_ok || r !== 32'd3 || out_valid !== 1'b1) $display("FAIL bp_hold: got r=%h v=%b in_ready=%b want r=3 v=1 in_ready=0", r, out_valid, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL bp_xor_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== 32'h0F) $display("FAIL bp_xor: got %h want %h", r, e.r);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        out_ready = 1'b1; in_valid = 1'b1; op = ADD;
        for (int i = 1; i <= 5; i++) begin
            a = W'(i); b = W'(i);
            sb.push_back(model(op, a, b));
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL stream_valid_%0d: got v=%b want 1", i, out_valid);
            else begin
                e = sb.pop_front();
                if ({r, zero, carry, ovf} !== e || r !== W'(2 * i)) $display("FAIL stream_%0d: got %h want %h", i, r, e.r);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        res_t e;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; op = MUL; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, r, zero, carry, ovf} !== '0) $display("FAIL midmul_reset: got v=%b r=%h z=%b c=%b o=%b want all 0", out_valid, r, zero, carry, ovf);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midmul_release: got in_ready=%b v=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        in_valid = 1'b1; op = AND; a = 32'hFF; b = 32'h0F;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL midmul_and_valid: got v=%b want 1", out_valid);
        else begin
            e = sb.pop_front();
            if ({r, zero, carry, ovf} !== e || r !== 32'h0F) $display("FAIL midmul_and: got %h want %h", r, e.r);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        res_t e;
        int cycles;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7));
            a = (i % 4 == 0) ? 32'h8000_0000 : W'($urandom);
            b = (i % 5 == 0) ? a : W'($urandom);
            sb.push_back(model(op, a, b));
            @(posedge clk); #1;
            in_valid = 1'b0;
            cycles = 0;
            while (out_valid !== 1'b1 && cycles < 40) begin
                @(posedge clk); #1;
                cycles++;
            end
            n_total++;
            if (out_valid !== 1'b1 || sb.size() == 0) $display("FAIL rand_%0d_timeout: op=%0d v=%b", i, op, out_valid);
            else begin
                e = sb.pop_front();
                if ({r, zero, carry, ovf} !== e) $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h/%b%b%b want %h/%b%b%b", i, op, a, b, r, zero, carry, ovf, e.r, e.zero, e.carry, e.ovf);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_srl();
        test_mul(32'd7, 32'd6, 32'd42);
        test_mul(32'h0001_0000, 32'h0001_0000, 32'd0);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
